// File: rtl/down_count_timer_pkg.sv
// Shared types and helpers for the down-counting timer.
//   state_t   : FSM state encoding (IDLE=0, RUN=1)
//   cnt_width : bits needed to hold values 0..n-1 (minimum 1)
package down_count_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // clog2-style width helper, never returns 0 so a 1-cycle prescaler still has a legal vector
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/down_count_timer_tick_prescaler.sv
// Prescaler for the down-counting timer: counts 0..PRESCALE-1 and flags the last cycle.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   clr     : synchronous clear to 0 (has priority over hold)
//   hold    : freeze the prescaler
//   tick_c  : combinational, high while the prescaler sits on its last value
// With PRESCALE=1 the only value is 0, so tick_c is constantly high.
module tick_prescaler
    import down_count_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic hold,
    output logic tick_c
);

    localparam int unsigned    PW   = cnt_width(PRESCALE);
    localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    // Wrapping prescale counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (!hold) begin
            pre <= (pre == LAST) ? '0 : pre + PW'(1);
        end
    end

    assign tick_c = (pre == LAST);

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counting timer with prescaled ticks and a one-cycle done pulse.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   load     : load load_val into count and the reload register (aborts a run)
//   load_val : value to load
//   start    : begin counting from the current count (ignored while running)
//   pause    : freeze count and prescaler while running
//   count    : current counter value (registered)
//   busy     : high in RUN (registered state)
//   done     : one-cycle pulse when the count reaches 0 (registered)
// Build option: define DOWN_COUNT_TIMER_AUTO_RELOAD_EN to restart from the reload
// register at the terminal tick instead of stopping (periodic done).
module down_count_timer
    import down_count_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] reload, reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             done_nxt;
    logic             pre_clr_c;
    logic             pre_hold_c;
    logic             tick_c;

    // Prescaler restarts on load and on an accepted start; it only runs in RUN unpaused
    assign pre_clr_c  = load || ((state == IDLE) && start);
    assign pre_hold_c = (state != RUN) || pause;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (pre_clr_c),
        .hold    (pre_hold_c),
        .tick_c  (tick_c)
    );

    // Next-state, count, reload and done logic; priority load > start > pause > tick
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        done_nxt   = 1'b0;

        if (load) begin
            count_nxt  = load_val;
            reload_nxt = load_val;
            state_nxt  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            state_nxt = RUN;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!pause && tick_c) begin
                        // <= 1 rather than == 1 so a stray zero can never wrap around
                        if (count <= WIDTH'(1)) begin
                            done_nxt = 1'b1;
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                            if (reload != '0) begin
                                count_nxt = reload;
                            end else begin
                                count_nxt = '0;
                                state_nxt = IDLE;
                            end
`else
                            count_nxt = '0;
                            state_nxt = IDLE;
`endif
                        end else begin
                            count_nxt = count - WIDTH'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            reload <= reload_nxt;
            done   <= done_nxt;
        end
    end

    assign busy = (state == RUN);

endmodule
